axil_regbank: RTL and testbench
===============================

AXIL_REGBANK -- requirements
Module: axil_regbank

Interface
REQ-001 Parameter: DATA_WIDTH, 32, data bus width; only 32 is supported.
REQ-002 Parameter: ADDR_WIDTH, 32, address bus width.
REQ-003 Parameter: BASE_ADDR, 0, byte base address of the bank; bits [4:0] are ignored.
REQ-004 Parameter: ID_VALUE, 32'hA5A5_0001, constant returned by the ID register.
REQ-005 S_AXI_aclk  in  1  single clock; all logic on its rising edge.
REQ-006 S_AXI_aresetn  in  1  reset; asynchronous assert, active-low.
REQ-007 S_AXI_awaddr/awprot/awvalid  in  ADDR_WIDTH/3/1; S_AXI_awready  out  1  write address channel.
REQ-008 S_AXI_wdata/wstrb/wvalid  in  32/4/1; S_AXI_wready  out  1  write data channel.
REQ-009 S_AXI_bresp  out  2; S_AXI_bvalid  out  1; S_AXI_bready  in  1  write response channel.
REQ-010 S_AXI_araddr/arprot/arvalid  in  ADDR_WIDTH/3/1; S_AXI_arready  out  1  read address channel.
REQ-011 S_AXI_rdata  out  32; S_AXI_rresp  out  2; S_AXI_rvalid  out  1; S_AXI_rready  in  1  read data channel.
REQ-012 awprot/arprot SHALL be ignored.

Function
REQ-013 Register map (offset = addr[4:2]): 0 SCRATCH0 RW; 1 SCRATCH1 RW; 2 CONTROL RW, only bit0 (CNT_EN) is implemented and the rest read 0; 3 COUNTER RO; 4 WR_COUNT RO; 5 RD_COUNT RO; 6 STATUS W1C, bit0 WERR and bit1 RERR; 7 ID RO = ID_VALUE.
REQ-014 In range SHALL mean addr[ADDR_WIDTH-1:5] == BASE_ADDR[ADDR_WIDTH-1:5]; otherwise the response SHALL be SLVERR (2'b10), with no register effect and rdata = 0.
REQ-015 In-range accesses SHALL return OKAY (2'b00); writes to RO registers SHALL be ignored and return OKAY.
REQ-016 RW writes SHALL honour wstrb per byte; W1C writes SHALL clear STATUS bits where wdata=1 and the byte strobe is set.
REQ-017 Write path: awready and wready SHALL each be 1 while that channel has no captured beat and bvalid=0, so AW and W can be accepted in either order or the same cycle.
REQ-018 When both beats are captured, the register write SHALL commit on the next edge and bvalid SHALL rise on that same edge.
REQ-019 bvalid/bresp SHALL hold until bready=1 is sampled; awready/wready SHALL return to 1 on the following cycle.
REQ-020 Read path: arready SHALL be 1 while rvalid=0; on the AR handshake edge rdata/rresp SHALL be registered and rvalid raised, for 1-cycle latency.
REQ-021 rvalid/rdata/rresp SHALL hold stable until rready=1 is sampled; arready SHALL be 0 while rvalid=1.
REQ-022 The read path SHALL be independent of the write path; a read SHALL sample register values before any write committing on the same edge.
REQ-023 COUNTER SHALL increment by 1 per cycle while CNT_EN=1 and wrap from 0xFFFF_FFFF to 0.
REQ-024 WR_COUNT SHALL increment on each OKAY write commit and wrap.
REQ-025 RD_COUNT SHALL increment on each OKAY AR handshake and wrap; a read of RD_COUNT SHALL return the pre-increment value.
REQ-026 WERR SHALL set on a SLVERR write commit and RERR on a SLVERR AR handshake; set SHALL win over a same-cycle W1C clear.

Reset
REQ-027 While aresetn=0, all outputs SHALL be 0 (awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata) and all registers SHALL be 0 except ID.
REQ-028 awready, wready and arready SHALL go to 1 on the first edge after aresetn is sampled high.
REQ-029 Reset asserted mid-transaction SHALL discard captured beats and pending responses with no register update.

Verification
REQ-030 After reset, write 0xDEADBEEF to BASE+0x00 with AW and W in the same cycle, then read it back -> OKAY, rdata 0xDEADBEEF, WR_COUNT=1, RD_COUNT=1.
REQ-031 W issued 3 cycles before AW, wstrb=4'b0011, data 0x12345678 to a SCRATCH1 that holds 0xFFFFFFFF -> SCRATCH1 = 0xFFFF5678; bvalid held 5 cycles with bready=0, then 1 cycle after bready awready=wready=1.
REQ-032 Write to BASE+0x20 -> bresp SLVERR, WERR=1, WR_COUNT unchanged; writing 0x1 to STATUS clears WERR.
REQ-033 Write CONTROL=1, then read COUNTER twice, N cycles apart -> difference = N; write CONTROL=0 -> COUNTER frozen.
REQ-034 Read ID with rready low for 4 cycles -> rdata stable at 0xA5A50001, arready=0 throughout.
REQ-035 Assert aresetn low while bvalid=1 -> bvalid=0 immediately; SCRATCH0 reads 0 after reset.

Source files
------------

// File: rtl/axil_regbank.sv
// axil_regbank: AXI4-Lite slave exposing eight 32-bit registers (scratch,
// control, free-running counter, transaction counters, sticky error status
// and a constant ID). Write and read paths are fully independent; every
// response is registered.
module axil_regbank #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter logic [31:0]           ID_VALUE   = 32'hA5A5_0001
) (
  input  logic                    S_AXI_aclk,
  input  logic                    S_AXI_aresetn,
  input  logic [ADDR_WIDTH-1:0]   S_AXI_awaddr,
  input  logic [2:0]              S_AXI_awprot,
  input  logic                    S_AXI_awvalid,
  output logic                    S_AXI_awready,
  input  logic [DATA_WIDTH-1:0]   S_AXI_wdata,
  input  logic [DATA_WIDTH/8-1:0] S_AXI_wstrb,
  input  logic                    S_AXI_wvalid,
  output logic                    S_AXI_wready,
  output logic [1:0]              S_AXI_bresp,
  output logic                    S_AXI_bvalid,
  input  logic                    S_AXI_bready,
  input  logic [ADDR_WIDTH-1:0]   S_AXI_araddr,
  input  logic [2:0]              S_AXI_arprot,
  input  logic                    S_AXI_arvalid,
  output logic                    S_AXI_arready,
  output logic [DATA_WIDTH-1:0]   S_AXI_rdata,
  output logic [1:0]              S_AXI_rresp,
  output logic                    S_AXI_rvalid,
  input  logic                    S_AXI_rready
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [2:0] OFS_SCRATCH0 = 3'd0;
  localparam logic [2:0] OFS_SCRATCH1 = 3'd1;
  localparam logic [2:0] OFS_CONTROL  = 3'd2;
  localparam logic [2:0] OFS_COUNTER  = 3'd3;
  localparam logic [2:0] OFS_WR_COUNT = 3'd4;
  localparam logic [2:0] OFS_RD_COUNT = 3'd5;
  localparam logic [2:0] OFS_STATUS   = 3'd6;

  // rdy_q holds all ready outputs low until the first edge out of reset
  logic                  rdy_q, rdy_d;
  logic                  aw_full_q, aw_full_d;
  logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
  logic                  w_full_q, w_full_d;
  logic [31:0]           w_data_q, w_data_d;
  logic [3:0]            w_strb_q, w_strb_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic                  rvalid_q, rvalid_d;
  logic [1:0]            rresp_q, rresp_d;
  logic [31:0]           rdata_q, rdata_d;
  logic [31:0]           scratch0_q, scratch0_d;
  logic [31:0]           scratch1_q, scratch1_d;
  logic                  cnt_en_q, cnt_en_d;
  logic [31:0]           counter_q, counter_d;
  logic [31:0]           wr_count_q, wr_count_d;
  logic [31:0]           rd_count_q, rd_count_d;
  logic                  werr_q, werr_d;
  logic                  rerr_q, rerr_d;

  logic        aw_hs, w_hs, ar_hs;
  logic        wr_commit, wr_in_range, wr_ok;
  logic        rd_in_range;
  logic [2:0]  wr_ofs, rd_ofs;
  logic [31:0] rd_mux;

  // Protection bits and sub-word address bits carry no meaning here
  logic unused_ok;
  assign unused_ok = ^{S_AXI_awprot, S_AXI_arprot, S_AXI_araddr[1:0], aw_addr_q[1:0]};

  assign S_AXI_awready = rdy_q & ~aw_full_q & ~bvalid_q;
  assign S_AXI_wready  = rdy_q & ~w_full_q & ~bvalid_q;
  assign S_AXI_arready = rdy_q & ~rvalid_q;
  assign S_AXI_bvalid  = bvalid_q;
  assign S_AXI_bresp   = bresp_q;
  assign S_AXI_rvalid  = rvalid_q;
  assign S_AXI_rresp   = rresp_q;
  assign S_AXI_rdata   = rdata_q;

  assign aw_hs       = S_AXI_awvalid & S_AXI_awready;
  assign w_hs        = S_AXI_wvalid & S_AXI_wready;
  assign ar_hs       = S_AXI_arvalid & S_AXI_arready;
  assign wr_commit   = aw_full_q & w_full_q & ~bvalid_q;
  assign wr_in_range = (aw_addr_q[ADDR_WIDTH-1:5] == BASE_ADDR[ADDR_WIDTH-1:5]);
  assign rd_in_range = (S_AXI_araddr[ADDR_WIDTH-1:5] == BASE_ADDR[ADDR_WIDTH-1:5]);
  assign wr_ok       = wr_commit & wr_in_range;
  assign wr_ofs      = aw_addr_q[4:2];
  assign rd_ofs      = S_AXI_araddr[4:2];

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

  // Write channel: capture AW and W independently, commit once both are held
  always_comb begin
    rdy_d     = 1'b1;
    aw_full_d = aw_full_q;
    aw_addr_d = aw_addr_q;
    w_full_d  = w_full_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    if (aw_hs) begin
      aw_full_d = 1'b1;
      aw_addr_d = S_AXI_awaddr;
    end
    if (w_hs) begin
      w_full_d = 1'b1;
      w_data_d = S_AXI_wdata[31:0];
      w_strb_d = S_AXI_wstrb[3:0];
    end
    if (wr_commit) begin
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = wr_in_range ? RESP_OKAY : RESP_SLVERR;
    end else if (bvalid_q && S_AXI_bready) begin
      bvalid_d = 1'b0;
      bresp_d  = RESP_OKAY;
    end
  end

  // Register file update: writes, free-running counter, activity counters, status
  always_comb begin
    scratch0_d = scratch0_q;
    scratch1_d = scratch1_q;
    cnt_en_d   = cnt_en_q;
    counter_d  = cnt_en_q ? counter_q + 32'd1 : counter_q;
    wr_count_d = wr_ok ? wr_count_q + 32'd1 : wr_count_q;
    rd_count_d = (ar_hs && rd_in_range) ? rd_count_q + 32'd1 : rd_count_q;
    werr_d     = werr_q;
    rerr_d     = rerr_q;
    if (wr_ok) begin
      case (wr_ofs)
        OFS_SCRATCH0: scratch0_d = merge_bytes(scratch0_q, w_data_q, w_strb_q);
        OFS_SCRATCH1: scratch1_d = merge_bytes(scratch1_q, w_data_q, w_strb_q);
        OFS_CONTROL:  if (w_strb_q[0]) cnt_en_d = w_data_q[0];
        OFS_STATUS: begin
          if (w_strb_q[0] && w_data_q[0]) werr_d = 1'b0;
          if (w_strb_q[0] && w_data_q[1]) rerr_d = 1'b0;
        end
        default: ;
      endcase
    end
    // Error sets come after the W1C clear so a same-cycle set survives
    if (wr_commit && !wr_in_range) werr_d = 1'b1;
    if (ar_hs && !rd_in_range)     rerr_d = 1'b1;
  end

  // Read mux over current register state (pre-update values)
  always_comb begin
    rd_mux = 32'h0;
    case (rd_ofs)
      OFS_SCRATCH0: rd_mux = scratch0_q;
      OFS_SCRATCH1: rd_mux = scratch1_q;
      OFS_CONTROL:  rd_mux = {31'h0, cnt_en_q};
      OFS_COUNTER:  rd_mux = counter_q;
      OFS_WR_COUNT: rd_mux = wr_count_q;
      OFS_RD_COUNT: rd_mux = rd_count_q;
      OFS_STATUS:   rd_mux = {30'h0, rerr_q, werr_q};
      default:      rd_mux = ID_VALUE;
    endcase
  end

  // Read channel: register the response on the AR handshake, hold until rready
  always_comb begin
    rvalid_d = rvalid_q;
    rresp_d  = rresp_q;
    rdata_d  = rdata_q;
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rresp_d  = rd_in_range ? RESP_OKAY : RESP_SLVERR;
      rdata_d  = rd_in_range ? rd_mux : 32'h0;
    end else if (rvalid_q && S_AXI_rready) begin
      rvalid_d = 1'b0;
    end
  end

  // State registers; reset drops every captured beat and pending response
  always_ff @(posedge S_AXI_aclk or negedge S_AXI_aresetn) begin
    if (!S_AXI_aresetn) begin
      rdy_q      <= 1'b0;
      aw_full_q  <= 1'b0;
      aw_addr_q  <= '0;
      w_full_q   <= 1'b0;
      w_data_q   <= 32'h0;
      w_strb_q   <= 4'h0;
      bvalid_q   <= 1'b0;
      bresp_q    <= 2'b00;
      rvalid_q   <= 1'b0;
      rresp_q    <= 2'b00;
      rdata_q    <= 32'h0;
      scratch0_q <= 32'h0;
      scratch1_q <= 32'h0;
      cnt_en_q   <= 1'b0;
      counter_q  <= 32'h0;
      wr_count_q <= 32'h0;
      rd_count_q <= 32'h0;
      werr_q     <= 1'b0;
      rerr_q     <= 1'b0;
    end else begin
      rdy_q      <= rdy_d;
      aw_full_q  <= aw_full_d;
      aw_addr_q  <= aw_addr_d;
      w_full_q   <= w_full_d;
      w_data_q   <= w_data_d;
      w_strb_q   <= w_strb_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      rvalid_q   <= rvalid_d;
      rresp_q    <= rresp_d;
      rdata_q    <= rdata_d;
      scratch0_q <= scratch0_d;
      scratch1_q <= scratch1_d;
      cnt_en_q   <= cnt_en_d;
      counter_q  <= counter_d;
      wr_count_q <= wr_count_d;
      rd_count_q <= rd_count_d;
      werr_q     <= werr_d;
      rerr_q     <= rerr_d;
    end
  end

endmodule

// File: tb/tb_axil_regbank.sv
// Testbench for axil_regbank: scoreboard of expected responses built from a
// small register model, one task per feature.
module tb_axil_regbank;

  localparam logic [31:0] ID = 32'hA5A5_0001;

  typedef struct packed {
    logic [1:0]  resp;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  exp_t       sb[$];
  logic [1:0] bq[$];

  logic [31:0] base_addr = 32'h0;
  logic [31:0] m_s0, m_s1, m_wr, m_rd;
  logic        m_ctrl, m_werr, m_rerr;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  axil_regbank dut (
    .S_AXI_aclk(clk), .S_AXI_aresetn(rst_n),
    .S_AXI_awaddr(awaddr), .S_AXI_awprot(awprot), .S_AXI_awvalid(awvalid), .S_AXI_awready(awready),
    .S_AXI_wdata(wdata), .S_AXI_wstrb(wstrb), .S_AXI_wvalid(wvalid), .S_AXI_wready(wready),
    .S_AXI_bresp(bresp), .S_AXI_bvalid(bvalid), .S_AXI_bready(bready),
    .S_AXI_araddr(araddr), .S_AXI_arprot(arprot), .S_AXI_arvalid(arvalid), .S_AXI_arready(arready),
    .S_AXI_rdata(rdata), .S_AXI_rresp(rresp), .S_AXI_rvalid(rvalid), .S_AXI_rready(rready)
  );

  // ---------------- register model ----------------
  task automatic model_reset();
    m_s0 = 0; m_s1 = 0; m_wr = 0; m_rd = 0;
    m_ctrl = 0; m_werr = 0; m_rerr = 0;
  endtask

  task automatic model_read(input logic [31:0] a, output exp_t e);
    if (a[31:5] != base_addr[31:5]) begin
      e.resp = 2'b10; e.data = 32'h0; m_rerr = 1'b1;
    end else begin
      e.resp = 2'b00;
      case (a[4:2])
        3'd0: e.data = m_s0;
        3'd1: e.data = m_s1;
        3'd2: e.data = {31'h0, m_ctrl};
        3'd3: e.data = 32'h0;
        3'd4: e.data = m_wr;
        3'd5: e.data = m_rd;
        3'd6: e.data = {30'h0, m_rerr, m_werr};
        default: e.data = ID;
      endcase
      m_rd = m_rd + 1;
    end
  endtask

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] r);
    if (a[31:5] != base_addr[31:5]) begin
      m_werr = 1'b1; r = 2'b10;
    end else begin
      r = 2'b00;
      for (int i = 0; i < 4; i++) begin
        if (s[i] && a[4:2] == 3'd0) m_s0[8*i +: 8] = d[8*i +: 8];
        if (s[i] && a[4:2] == 3'd1) m_s1[8*i +: 8] = d[8*i +: 8];
      end
      if (a[4:2] == 3'd2 && s[0]) m_ctrl = d[0];
      if (a[4:2] == 3'd6 && s[0]) begin
        if (d[0]) m_werr = 1'b0;
        if (d[1]) m_rerr = 1'b0;
      end
      m_wr = m_wr + 1;
    end
  endtask

  // ---------------- bus tasks (entered/left 1 time unit after a rising edge) ----------------
  task automatic drive_beats(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             input bit do_aw, input bit do_w);
    bit aw_p, w_p, aw_h, w_h;
    aw_p = do_aw; w_p = do_w;
    if (do_aw) begin awvalid = 1'b1; awaddr = a; end
    if (do_w)  begin wvalid = 1'b1; wdata = d; wstrb = s; end
    for (int i = 0; i < 50 && (aw_p || w_p); i++) begin
      aw_h = aw_p && awready;
      w_h  = w_p && wready;
      @(posedge clk); #1;
      if (aw_h) begin aw_p = 1'b0; awvalid = 1'b0; end
      if (w_h)  begin w_p = 1'b0; wvalid = 1'b0; end
    end
    if (aw_p || w_p) begin
      checks++; errors++;
      $display("FAIL write_handshake_timeout addr=%h aw_pending=%0d w_pending=%0d", a, aw_p, w_p);
      awvalid = 1'b0; wvalid = 1'b0;
    end
  endtask

  task automatic get_b(output logic [1:0] r);
    bit got;
    got = 1'b0; r = 2'bxx;
    bready = 1'b1;
    for (int i = 0; i < 50 && !got; i++) begin
      if (bvalid) begin r = bresp; got = 1'b1; end
      @(posedge clk); #1;
    end
    bready = 1'b0;
    if (!got) begin
      checks++; errors++;
      $display("FAIL bresp_timeout bvalid never seen, required 1");
    end
  endtask

  task automatic axi_read(input logic [31:0] a, output logic [1:0] r, output logic [31:0] d,
                          output int hs_cyc, output int lat);
    bit done, h, got;
    done = 1'b0; got = 1'b0; r = 2'bxx; d = 'x; hs_cyc = 0; lat = -1;
    arvalid = 1'b1; araddr = a;
    for (int i = 0; i < 50 && !done; i++) begin
      h = arready;
      @(posedge clk); #1;
      if (h) begin done = 1'b1; arvalid = 1'b0; hs_cyc = cyc; end
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL ar_handshake_timeout addr=%h arready never seen", a);
      arvalid = 1'b0;
    end
    rready = 1'b1;
    for (int i = 0; i < 50 && !got; i++) begin
      if (rvalid) begin r = rresp; d = rdata; got = 1'b1; lat = i; end
      @(posedge clk); #1;
    end
    rready = 1'b0;
    if (!got) begin
      checks++; errors++;
      $display("FAIL rvalid_timeout addr=%h rvalid never seen", a);
    end
  endtask

  task automatic apply_reset();
    awvalid = 0; wvalid = 0; arvalid = 0; bready = 0; rready = 0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    model_reset();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    exp_t e; logic [1:0] r; logic [31:0] d; int hc, lat;
    rst_n = 1'b0;
    repeat (2) @(posedge clk); #1;
    checks++;
    if ({awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata} !== 41'h0) begin
      errors++;
      $display("FAIL reset_outputs got ready=%b%b%b bv=%b rv=%b bresp=%b rresp=%b rdata=%h required all 0",
               awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if ({awready, wready, arready} !== 3'b000) begin
      errors++; $display("FAIL ready_before_edge got %b required 000", {awready, wready, arready});
    end
    @(posedge clk); #1;
    checks++;
    if ({awready, wready, arready} !== 3'b111) begin
      errors++; $display("FAIL ready_after_edge got %b required 111", {awready, wready, arready});
    end
    model_reset();
    for (int i = 0; i < 8; i++) begin
      model_read(32'(i * 4), e);
      sb.push_back(e);
      axi_read(32'(i * 4), r, d, hc, lat);
      e = sb.pop_front();
      checks++;
      if ({r, d} !== {e.resp, e.data}) begin
        errors++;
        $display("FAIL reset_reg_%0d got resp=%b data=%h required resp=%b data=%h", i, r, d, e.resp, e.data);
      end
    end
  endtask

  task automatic test_basic();
    exp_t e; logic [1:0] r, er; logic [31:0] a, d; int hc, lat;
    apply_reset();
    model_write(32'h0, 32'hDEAD_BEEF, 4'hF, er);
    bq.push_back(er);
    drive_beats(32'h0, 32'hDEAD_BEEF, 4'hF, 1, 1);
    get_b(r);
    er = bq.pop_front();
    checks++;
    if (r !== er) begin errors++; $display("FAIL basic_bresp got %b required %b", r, er); end
    for (int i = 0; i < 3; i++) begin
      a = (i == 0) ? 32'h00 : (i == 1) ? 32'h14 : 32'h10;
      model_read(a, e);
      sb.push_back(e);
      axi_read(a, r, d, hc, lat);
      e = sb.pop_front();
      checks++;
      if ({r, d} !== {e.resp, e.data}) begin
        errors++;
        $display("FAIL basic_read_%h got resp=%b data=%h required resp=%b data=%h", a, r, d, e.resp, e.data);
      end
      if (i == 0) begin
        checks++;
        if (lat !== 0) begin errors++; $display("FAIL read_latency got %0d extra cycles required 0", lat); end
      end
    end
  endtask

  task automatic test_strobe();
    exp_t e; logic [1:0] r, er; logic [31:0] d; int hc, lat;
    model_write(32'h4, 32'hFFFF_FFFF, 4'hF, er);
    drive_beats(32'h4, 32'hFFFF_FFFF, 4'hF, 1, 1);
    get_b(r);
    checks++;
    if (r !== er) begin errors++; $display("FAIL strobe_prefill_bresp got %b required %b", r, er); end
    model_write(32'h4, 32'h1234_5678, 4'b0011, er);
    bq.push_back(er);
    wvalid = 1'b1; wdata = 32'h1234_5678; wstrb = 4'b0011;
    @(posedge clk); #1;
    wvalid = 1'b0;
    checks++;
    if ({wready, awready, bvalid} !== 3'b010) begin
      errors++; $display("FAIL strobe_w_only got wready,awready,bvalid=%b required 010", {wready, awready, bvalid});
    end
    repeat (2) @(posedge clk); #1;
    awvalid = 1'b1; awaddr = 32'h4;
    @(posedge clk); #1;
    awvalid = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({bvalid, bresp, awready, wready} !== 5'b1_00_00) begin
        errors++;
        $display("FAIL bvalid_hold_%0d got bvalid=%b bresp=%b awready=%b wready=%b required 1 00 0 0",
                 i, bvalid, bresp, awready, wready);
      end
      @(posedge clk); #1;
    end
    bready = 1'b1;
    r = bresp;
    @(posedge clk); #1;
    bready = 1'b0;
    er = bq.pop_front();
    checks++;
    if (r !== er) begin errors++; $display("FAIL strobe_bresp got %b required %b", r, er); end
    checks++;
    if ({bvalid, awready, wready} !== 3'b011) begin
      errors++; $display("FAIL after_bready got bvalid,awready,wready=%b required 011", {bvalid, awready, wready});
    end
    model_read(32'h4, e);
    sb.push_back(e);
    axi_read(32'h4, r, d, hc, lat);
    e = sb.pop_front();
    checks++;
    if ({r, d} !== {e.resp, e.data} || d !== 32'hFFFF_5678) begin
      errors++; $display("FAIL strobe_readback got resp=%b data=%h required resp=00 data=ffff5678", r, d);
    end
  endtask

  task automatic test_slverr();
    logic [31:0] oa[16], od[16]; logic [3:0] os[16]; bit ow[16];
    exp_t e; logic [1:0] r, er; logic [31:0] d; int hc, lat;
    oa = '{32'h20, 32'h18, 32'h10, 32'h20, 32'h18, 32'h18, 32'h18, 32'h18,
           32'h18, 32'h18, 32'h18, 32'h1C, 32'h1C, 32'h1000_0004, 32'h04, 32'h10};
    od = '{32'h1, 0, 0, 0, 0, 32'h1, 0, 32'h2, 0, 32'h2, 0, 32'h0, 0, 32'h0BAD_0BAD, 0, 0};
    os = '{4'hF, 0, 0, 0, 0, 4'hF, 0, 4'h0, 0, 4'h1, 0, 4'hF, 0, 4'hF, 0, 0};
    ow = '{1, 0, 0, 0, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 0};
    for (int i = 0; i < 16; i++) begin
      if (ow[i]) begin
        model_write(oa[i], od[i], os[i], er);
        bq.push_back(er);
        drive_beats(oa[i], od[i], os[i], 1, 1);
        get_b(r);
        er = bq.pop_front();
        checks++;
        if (r !== er) begin errors++; $display("FAIL err_step%0d_bresp got %b required %b", i, r, er); end
      end else begin
        model_read(oa[i], e);
        sb.push_back(e);
        axi_read(oa[i], r, d, hc, lat);
        e = sb.pop_front();
        checks++;
        if ({r, d} !== {e.resp, e.data}) begin
          errors++;
          $display("FAIL err_step%0d_read got resp=%b data=%h required resp=%b data=%h", i, r, d, e.resp, e.data);
        end
      end
    end
  endtask

  task automatic test_counter();
    exp_t e; logic [1:0] r, er; logic [31:0] d, c1, c2, c3, c4; int h1, h2, lat;
    model_write(32'h8, 32'hFFFF_FFFF, 4'hF, er);
    drive_beats(32'h8, 32'hFFFF_FFFF, 4'hF, 1, 1);
    get_b(r);
    checks++;
    if (r !== er) begin errors++; $display("FAIL ctrl_bresp got %b required %b", r, er); end
    model_read(32'h8, e);
    sb.push_back(e);
    axi_read(32'h8, r, d, h1, lat);
    e = sb.pop_front();
    checks++;
    if ({r, d} !== {e.resp, e.data}) begin
      errors++; $display("FAIL ctrl_read got resp=%b data=%h required resp=%b data=%h", r, d, e.resp, e.data);
    end
    model_read(32'hC, e);
    axi_read(32'hC, r, c1, h1, lat);
    repeat (10) @(posedge clk); #1;
    model_read(32'hC, e);
    axi_read(32'hC, r, c2, h2, lat);
    checks++;
    if ((c2 - c1) !== 32'(h2 - h1)) begin
      errors++; $display("FAIL counter_delta got %0d required %0d", c2 - c1, h2 - h1);
    end
    model_write(32'h8, 32'h0, 4'hF, er);
    drive_beats(32'h8, 32'h0, 4'hF, 1, 1);
    get_b(r);
    model_read(32'hC, e);
    axi_read(32'hC, r, c3, h1, lat);
    repeat (5) @(posedge clk); #1;
    model_read(32'hC, e);
    axi_read(32'hC, r, c4, h2, lat);
    checks++;
    if (c4 !== c3 || c3 == 32'h0) begin
      errors++; $display("FAIL counter_frozen got %h then %h required equal and nonzero", c3, c4);
    end
  endtask

  task automatic test_read_hold();
    exp_t e; bit done, h;
    done = 1'b0;
    model_read(32'h1C, e);
    sb.push_back(e);
    rready = 1'b0; arvalid = 1'b1; araddr = 32'h1C;
    for (int i = 0; i < 50 && !done; i++) begin
      h = arready;
      @(posedge clk); #1;
      if (h) begin done = 1'b1; arvalid = 1'b0; end
    end
    arvalid = 1'b0;
    e = sb.pop_front();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({rvalid, arready, rresp, rdata} !== {1'b1, 1'b0, e.resp, e.data}) begin
        errors++;
        $display("FAIL read_hold_%0d got rvalid=%b arready=%b rresp=%b rdata=%h required 1 0 %b %h",
                 i, rvalid, arready, rresp, rdata, e.resp, e.data);
      end
      @(posedge clk); #1;
    end
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
    checks++;
    if ({rvalid, arready} !== 2'b01) begin
      errors++; $display("FAIL read_release got rvalid,arready=%b required 01", {rvalid, arready});
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] pool[8];
    exp_t e; logic [1:0] r, er; logic [31:0] a, d, wd; logic [3:0] ws; int hc, lat;
    pool = '{32'h00, 32'h04, 32'h08, 32'h10, 32'h14, 32'h18, 32'h1C, 32'h40};
    for (int i = 0; i < 24; i++) begin
      a  = pool[$urandom_range(0, 7)];
      wd = $urandom;
      ws = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) begin
        model_write(a, wd, ws, er);
        bq.push_back(er);
        drive_beats(a, wd, ws, 1, 1);
        get_b(r);
        er = bq.pop_front();
        checks++;
        if (r !== er) begin errors++; $display("FAIL b2b_%0d_bresp addr=%h got %b required %b", i, a, r, er); end
      end else begin
        model_read(a, e);
        sb.push_back(e);
        axi_read(a, r, d, hc, lat);
        e = sb.pop_front();
        checks++;
        if ({r, d} !== {e.resp, e.data}) begin
          errors++;
          $display("FAIL b2b_%0d_read addr=%h got resp=%b data=%h required resp=%b data=%h",
                   i, a, r, d, e.resp, e.data);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_t e; logic [1:0] r, er; logic [31:0] d, a; int hc, lat;
    bready = 1'b0;
    drive_beats(32'h0, 32'hCAFE_F00D, 4'hF, 1, 1);
    @(posedge clk); #1;
    checks++;
    if (bvalid !== 1'b1) begin errors++; $display("FAIL mid_bvalid_pre got %b required 1", bvalid); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bvalid, awready, wready, arready} !== 4'b0000) begin
      errors++; $display("FAIL mid_reset_async got bvalid,awready,wready,arready=%b required 0000",
                         {bvalid, awready, wready, arready});
    end
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    model_reset();
    drive_beats(32'h0, 32'h5555_AAAA, 4'hF, 1, 0);
    rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    model_reset();
    drive_beats(32'h0, 32'h0000_1234, 4'hF, 0, 1);
    repeat (3) @(posedge clk); #1;
    checks++;
    if (bvalid !== 1'b0) begin errors++; $display("FAIL stale_aw_commit got bvalid=%b required 0", bvalid); end
    model_write(32'h4, 32'h0000_1234, 4'hF, er);
    drive_beats(32'h4, 32'h0, 4'h0, 1, 0);
    get_b(r);
    checks++;
    if (r !== er) begin errors++; $display("FAIL mid_bresp got %b required %b", r, er); end
    for (int i = 0; i < 2; i++) begin
      a = 32'(i * 4);
      model_read(a, e);
      sb.push_back(e);
      axi_read(a, r, d, hc, lat);
      e = sb.pop_front();
      checks++;
      if ({r, d} !== {e.resp, e.data}) begin
        errors++;
        $display("FAIL mid_read_%h got resp=%b data=%h required resp=%b data=%h", a, r, d, e.resp, e.data);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    awaddr = 0; awprot = 0; awvalid = 0; wdata = 0; wstrb = 0; wvalid = 0; bready = 0;
    araddr = 0; arprot = 0; arvalid = 0; rready = 0;
    model_reset();
    test_reset();
    test_basic();
    test_strobe();
    test_slverr();
    test_counter();
    test_read_hold();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
